// File: rtl/pipe_stall_ctl.sv
// Pipeline stall controller: load-use bubbles, data-memory wait stalls, timeout halt.
// Latency: stall controls are combinational from state and inputs; state/counters update on clock rise.
// Backpressure: wpcir=0 holds PC and IF/ID; mstall=1 freezes ID/EX..MEM/WB. Macro PIPE_STALL_CNT_EN enables stall_cnt.
module pipe_stall_ctl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic        use_rs,
   input  logic        use_rt,
   input  logic [4:0]  ern,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic        mmem_req,
   input  logic        dmem_ready,
   input  logic        resume,
   output logic        wpcir,
   output logic        dbubble,
   output logic        mstall,
   output logic        mem_err,
   output logic [1:0]  state,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MWAIT = 2'd1,
      ST_HALT  = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       lu;

   // Load-use hazard: EX holds a load whose destination feeds an ID source.
   always_comb begin
      lu = ewreg & em2reg & (ern != 5'd0) &
           ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
   end

   // Next-state and stall outputs; memory stall outranks the load-use bubble.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wpcir      = 1'b1;
      dbubble    = 1'b0;
      mstall     = 1'b0;
      mem_err    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mmem_req && !dmem_ready) begin
               wpcir      = 1'b0;
               mstall     = 1'b1;
               state_d    = ST_MWAIT;
               wait_cnt_d = 8'd1;
            end else if (lu) begin
               wpcir   = 1'b0;
               dbubble = 1'b1;
            end
         end
         ST_MWAIT: begin
            if (dmem_ready) begin
               // Access completes now, so the ID-stage hazard check applies again.
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
               if (lu) begin
                  wpcir   = 1'b0;
                  dbubble = 1'b1;
               end
            end else if (wait_cnt_q < TIMEOUT_C) begin
               wpcir      = 1'b0;
               mstall     = 1'b1;
               wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
               wpcir   = 1'b0;
               mstall  = 1'b1;
               mem_err = 1'b1;
               state_d = ST_HALT;
            end
         end
         default: begin
            // HALT, and the unused encoding which behaves identically.
            wpcir  = 1'b0;
            mstall = 1'b1;
            if (resume) begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
            end
         end
      endcase
      if (!resetn) begin
         wpcir   = 1'b1;
         dbubble = 1'b0;
         mstall  = 1'b0;
         mem_err = 1'b0;
      end
   end

   // State and memory-wait counter registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign state = state_q;

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count every non-reset cycle in which the front end is held; wraps naturally.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!wpcir) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Stall counter register.
   always_ff @(posedge clock) begin
      if (!resetn) stall_cnt_q <= 32'd0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctl.sv
// Scoreboard bench for pipe_stall_ctl built with TIMEOUT=4.
// Driver applies one directed vector per cycle and queues its expected outputs.
// Monitor samples mid-cycle and compares against the queue head.
module tb_pipe_stall_ctl;

   logic        clock;
   logic        resetn;
   logic [4:0]  rs, rt, ern;
   logic        use_rs, use_rt, ewreg, em2reg, mmem_req, dmem_ready, resume;
   logic        wpcir, dbubble, mstall, mem_err;
   logic [1:0]  state;
   logic [31:0] stall_cnt;

   typedef struct {
      logic        w, b, m, e;
      logic [1:0]  s;
      logic [31:0] cnt;
      string       nm;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_cnt = 32'd0;

   pipe_stall_ctl #(.TIMEOUT(4)) dut (
      .clock(clock), .resetn(resetn), .rs(rs), .rt(rt),
      .use_rs(use_rs), .use_rt(use_rt), .ern(ern), .ewreg(ewreg),
      .em2reg(em2reg), .mmem_req(mmem_req), .dmem_ready(dmem_ready),
      .resume(resume), .wpcir(wpcir), .dbubble(dbubble), .mstall(mstall),
      .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Apply one vector for a cycle and queue its hand-computed response.
   task automatic vec(input bit rn, input logic [4:0] rs_v, input logic [4:0] rt_v,
                      input bit urs, input bit urt, input logic [4:0] ern_v,
                      input bit ew, input bit em, input bit mreq, input bit rdy,
                      input bit res, input bit xw, input bit xb, input bit xm,
                      input bit xe, input logic [1:0] xs, input string nm);
      exp_t x;
      @(posedge clock);
      #1;
      resetn = rn; rs = rs_v; rt = rt_v; use_rs = urs; use_rt = urt;
      ern = ern_v; ewreg = ew; em2reg = em; mmem_req = mreq;
      dmem_ready = rdy; resume = res;
      x.w = xw; x.b = xb; x.m = xm; x.e = xe; x.s = xs; x.nm = nm;
`ifdef PIPE_STALL_CNT_EN
      x.cnt = model_cnt;
`else
      x.cnt = 32'd0;
`endif
      sb_q.push_back(x);
      if (!rn)      model_cnt = 32'd0;
      else if (!xw) model_cnt = model_cnt + 32'd1;
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            checks++;
            if (wpcir !== x.w || dbubble !== x.b || mstall !== x.m ||
                mem_err !== x.e || state !== x.s || stall_cnt !== x.cnt) begin
               errors++;
               $display("FAIL %s: got w=%b b=%b m=%b e=%b s=%0d cnt=%0d, want w=%b b=%b m=%b e=%b s=%0d cnt=%0d",
                        x.nm, wpcir, dbubble, mstall, mem_err, state, stall_cnt,
                        x.w, x.b, x.m, x.e, x.s, x.cnt);
            end
         end
      end
   end

   initial begin
      resetn = 1'b0; rs = '0; rt = '0; ern = '0; use_rs = 0; use_rt = 0;
      ewreg = 0; em2reg = 0; mmem_req = 0; dmem_ready = 0; resume = 0;
      repeat (2) @(posedge clock);
      //   rn rs rt  urs urt ern ew em mrq rdy res | w b m e s
      vec(0, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0,   1, 0, 0, 0, 0, "reset_outputs");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "idle");
      vec(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0, "lu_rs");
      vec(1, 5, 0, 1, 0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, "lu_ern0");
      vec(1, 0, 7, 0, 1, 7, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0, "lu_rt");
      vec(1, 0, 7, 0, 0, 7, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, "no_lu_unused_rt");
      vec(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, "no_lu_not_load");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, "mstall_c1");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, "mstall_c2");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, "mstall_c3");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0, 0, 0, 1, "mwait_ready");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "back_to_run");
      vec(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0, "mem_over_lu");
      vec(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0,   0, 0, 1, 0, 1, "mwait_lu_held");
      vec(1, 5, 0, 1, 0, 5, 1, 1, 1, 1, 0,   0, 1, 0, 0, 1, "ready_then_lu");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "run_after_lu");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 1, 0, 0, "to_c1_resume_ign");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 1, 0, 1, "to_c2_resume_ign");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, "to_c3");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 1, "to_c4");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 1, 1, "to_c5_mem_err");
      vec(1, 5, 0, 1, 0, 5, 1, 1, 1, 1, 0,   0, 0, 1, 0, 2, "halt_ignores_inputs");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2, "halt_hold");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 2, "halt_resume");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "resumed_run");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, "pre_reset_stall");
      vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 1, "reset_in_mwait");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "after_reset");
      vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, "final_idle");
      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
      @(posedge clock);
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d entries pending, want 0", sb_q.size());
      end
      if (checks < 29) begin
         errors++;
         $display("FAIL check_count: got %0d, want 29", checks);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctl.md
PIPE_STALL_CTL -- requirements
Module: pipe_stall_ctl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum memory-wait cycles before abort; legal range 2..255.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 rs, rt  in  5 each  ID-stage source register numbers.
REQ-005 use_rs, use_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 ern  in  5  EX-stage destination register.
REQ-007 ewreg, em2reg  in  1 each  EX instruction writes regfile / is a load.
REQ-008 mmem_req  in  1  MEM-stage instruction accesses data memory.
REQ-009 dmem_ready  in  1  data memory completes access this cycle.
REQ-010 resume  in  1  leave HALT state.
REQ-011 wpcir  out  1  1 = PC and IF/ID register load; 0 = hold.
REQ-012 dbubble  out  1  1 = zero the control fields written into ID/EX.
REQ-013 mstall  out  1  1 = hold ID/EX, EX/MEM and MEM/WB registers.
REQ-014 mem_err  out  1  one-cycle pulse on memory-wait timeout.
REQ-015 state  out  2  current FSM state: 0 RUN, 1 MWAIT, 2 HALT.
REQ-016 stall_cnt  out  32  count of cycles with wpcir=0.

Function
REQ-017 Load-use hazard lu = ewreg & em2reg & (ern!=0) & ((use_rs & ern==rs) | (use_rt & ern==rt)), combinational.
REQ-018 RUN, mmem_req & ~dmem_ready: wpcir=0, mstall=1, dbubble=0; next MWAIT; wait_cnt<=1.
REQ-019 RUN, memory not stalling and lu=1: wpcir=0, dbubble=1, mstall=0; state stays RUN.
REQ-020 RUN, neither condition: wpcir=1, dbubble=0, mstall=0.
REQ-021 Memory stall takes priority over lu; dbubble is never 1 while mstall=1.
REQ-022 MWAIT, dmem_ready=1: wpcir=1, mstall=0 that same cycle (lu evaluated per REQ-019); next RUN; wait_cnt<=0.
REQ-023 MWAIT, dmem_ready=0, wait_cnt<TIMEOUT: wpcir=0, mstall=1; wait_cnt increments.
REQ-024 MWAIT, dmem_ready=0, wait_cnt==TIMEOUT: mem_err=1 for this cycle only, wpcir=0, mstall=1; next HALT.
REQ-025 HALT: wpcir=0, mstall=1, dbubble=0 regardless of other inputs; resume=1 -> next RUN; resume ignored in RUN and MWAIT.
REQ-026 dmem_ready and timeout in the same cycle: ready wins, no mem_err.
REQ-027 wpcir, dbubble, mstall, mem_err are combinational from state and inputs; state, wait_cnt, stall_cnt are registered.
REQ-028 State encoding 3 is unreachable; if reached, treated as HALT.

Reset
REQ-029 resetn=0 at a rising edge: state<=RUN, wait_cnt<=0, stall_cnt<=0, regardless of current state including mid-MWAIT.
REQ-030 While resetn=0: wpcir=1, dbubble=0, mstall=0, mem_err=0.

Configuration
REQ-031 Macro PIPE_STALL_CNT_EN defined: stall_cnt increments by 1 each non-reset cycle with wpcir=0, wrapping 0xFFFFFFFF->0.
REQ-032 PIPE_STALL_CNT_EN undefined: no counter register; stall_cnt tied to 0; port list unchanged.

Verification
REQ-033 ern=5, ewreg=1, em2reg=1, rs=5, use_rs=1 -> wpcir=0, dbubble=1, state=0; next cycle with ern=0 -> wpcir=1.
REQ-034 Same load-use with ern=0 -> wpcir=1, dbubble=0.
REQ-035 mmem_req=1, dmem_ready low for 3 cycles then high -> mstall=1 for 3 cycles, state=1 for cycles 2-4 of the stall sequence, wpcir=1 on ready cycle, no mem_err.
REQ-036 TIMEOUT=4, dmem_ready held low -> mem_err pulses once on 5th stall cycle, state=2 thereafter; resume=1 -> state=0 next cycle.
REQ-037 Memory stall plus concurrent lu -> dbubble=0, mstall=1; resetn=0 during MWAIT -> state=0, stall_cnt=0 next cycle.
REQ-038 PIPE_STALL_CNT_EN defined, 7 stalled cycles -> stall_cnt=7; undefined -> stall_cnt=0.
